// File: rtl/db_target_resp_pkg.sv
// Shared constants, state encoding and helpers for the doorbell/NWR target responder.
package db_target_resp_pkg;

  localparam logic [3:0] FTYPE_DB   = 4'hA;
  localparam logic [3:0] FTYPE_NWR  = 4'h5;
  localparam logic [3:0] TTYPE_NWR  = 4'h4;

  localparam logic [15:0] DB_SELF       = 16'h0101;
  localparam logic [15:0] DB_SELF_OK    = 16'h0100;
  localparam logic [15:0] DB_SELF_BUSY  = 16'h01FF;
  localparam logic [15:0] DB_INTEG      = 16'h0200;
  localparam logic [15:0] DB_INTEG_OK   = 16'h0300;
  localparam logic [15:0] DB_INTEG_BAD  = 16'h03FF;
  localparam logic [15:0] DB_UNKNOWN    = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE,
    DB_RESP,
    NWR_DATA,
    DISCARD
  } state_t;

  function automatic logic [5:0] sat_inc6(input logic [5:0] v);
    return (v == 6'd63) ? v : v + 6'd1;
  endfunction

endpackage

// File: rtl/db_target_resp.sv
// Target-side responder: answers doorbells with a single-beat reply and streams
// NWR payload out with the beat count kept for later integrity doorbells.
module db_target_resp
  import db_target_resp_pkg::*;
(
  input  logic        log_clk,
  input  logic        log_rst,
  input  logic [7:0]  src_id,
  input  logic        local_busy,
  input  logic        treq_tvalid_in,
  output logic        treq_tready_o,
  input  logic        treq_tlast_in,
  input  logic [63:0] treq_tdata_in,
  input  logic [7:0]  treq_tkeep_in,
  input  logic [31:0] treq_tuser_in,
  output logic        tresp_tvalid_o,
  input  logic        tresp_tready_in,
  output logic        tresp_tlast_o,
  output logic [63:0] tresp_tdata_o,
  output logic [7:0]  tresp_tkeep_o,
  output logic [31:0] tresp_tuser_o,
  output logic        nwr_valid_o,
  output logic [63:0] nwr_data_o,
  output logic [7:0]  nwr_keep_o,
  output logic        nwr_last_o,
  output logic [33:0] nwr_addr_o,
  output logic        integ_pulse_o
);

  state_t      state;
  logic [5:0]  beat_cnt;
  logic [5:0]  last_cnt;
  logic [7:0]  nwr_size;
  logic        db_tlast;

  logic [7:0]  h_tid;
  logic [3:0]  h_ftype;
  logic [3:0]  h_ttype;
  logic [1:0]  h_prio;
  logic [1:0]  prio_next;
  logic [7:0]  h_size;
  logic [33:0] h_addr;
  logic [15:0] h_info;
  logic [15:0] info_next;
  logic [5:0]  want_cnt;
  logic [5:0]  cnt_next;
  logic        is_integ;
  logic        unused_bits;

  assign h_tid     = treq_tdata_in[63:56];
  assign h_ftype   = treq_tdata_in[55:52];
  assign h_ttype   = treq_tdata_in[51:48];
  assign h_prio    = treq_tdata_in[46:45];
  assign h_size    = treq_tdata_in[43:36];
  assign h_addr    = treq_tdata_in[33:0];
  assign h_info    = treq_tdata_in[31:16];
  assign prio_next = h_prio + 2'd1;
  assign want_cnt  = {1'b0, nwr_size[7:3]} + 6'd1;
  assign cnt_next  = sat_inc6(beat_cnt);
  assign is_integ  = (h_info[15:1] == DB_INTEG[15:1]);

  assign unused_bits = ^{treq_tuser_in[15:0], treq_tdata_in[47], treq_tdata_in[44],
                         treq_tdata_in[35:34], nwr_size[2:0]};

  assign treq_tready_o = (state != DB_RESP);
  assign tresp_tlast_o = tresp_tvalid_o;
  assign tresp_tkeep_o = {8{tresp_tvalid_o}};

  // Integrity check compares against the most recently completed NWR.
  always_comb begin
    info_next = DB_UNKNOWN;
    if (h_info == DB_SELF)
      info_next = local_busy ? DB_SELF_BUSY : DB_SELF_OK;
    else if (is_integ)
      info_next = (last_cnt == want_cnt && nwr_addr_o[20] == h_info[0])
                  ? (DB_INTEG_OK | {15'h0, h_info[0]}) : DB_INTEG_BAD;
  end

  always_ff @(posedge log_clk or posedge log_rst) begin
    if (log_rst) begin
      state          <= IDLE;
      beat_cnt       <= '0;
      last_cnt       <= '0;
      nwr_size       <= '0;
      db_tlast       <= 1'b0;
      tresp_tvalid_o <= 1'b0;
      tresp_tdata_o  <= '0;
      tresp_tuser_o  <= '0;
      nwr_valid_o    <= 1'b0;
      nwr_data_o     <= '0;
      nwr_keep_o     <= '0;
      nwr_last_o     <= 1'b0;
      nwr_addr_o     <= '0;
      integ_pulse_o  <= 1'b0;
    end else begin
      nwr_valid_o   <= 1'b0;
      integ_pulse_o <= 1'b0;
      case (state)
        IDLE: begin
          if (treq_tvalid_in) begin
            if (h_ftype == FTYPE_DB) begin
              state          <= DB_RESP;
              db_tlast       <= treq_tlast_in;
              tresp_tvalid_o <= 1'b1;
              tresp_tdata_o  <= {h_tid, FTYPE_DB, 4'h0, 1'b0, prio_next, 1'b0,
                                 12'h0, info_next, 16'h0};
              tresp_tuser_o  <= {8'h0, src_id, treq_tuser_in[31:16]};
              integ_pulse_o  <= is_integ;
            end else if (h_ftype == FTYPE_NWR && h_ttype == TTYPE_NWR) begin
              nwr_addr_o <= h_addr;
              nwr_size   <= h_size;
              beat_cnt   <= '0;
              // Payload-less or busy-dropped writes still count as "completed" with 0 beats.
              if (treq_tlast_in || local_busy)
                last_cnt <= '0;
              if (!treq_tlast_in)
                state <= local_busy ? DISCARD : NWR_DATA;
            end else if (!treq_tlast_in) begin
              state <= DISCARD;
            end
          end
        end
        NWR_DATA: begin
          if (treq_tvalid_in) begin
            nwr_valid_o <= 1'b1;
            nwr_data_o  <= treq_tdata_in;
            nwr_keep_o  <= treq_tkeep_in;
            nwr_last_o  <= treq_tlast_in;
            beat_cnt    <= cnt_next;
            if (treq_tlast_in) begin
              last_cnt <= cnt_next;
              state    <= IDLE;
            end
          end
        end
        DISCARD: begin
          if (treq_tvalid_in && treq_tlast_in)
            state <= IDLE;
        end
        DB_RESP: begin
          if (tresp_tready_in) begin
            tresp_tvalid_o <= 1'b0;
            state          <= db_tlast ? IDLE : DISCARD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
